input_conditioner_array: RTL and testbench
==========================================

# input_conditioner_array

Parametrised, multi-channel successor to the single-bit input conditioner. Each of CHANNELS asynchronous inputs is synchronised into the clk domain through a configurable-depth flop chain, debounced, and turned into a conditioned level plus one-cycle rising/falling edge pulses. Per-channel fault forcing, sticky edge-event flags with a software clear, and an aggregate interrupt-style event output are added. It sits between board-level buttons/switches and the datapath/control FSMs that consume clean edges.

## Interface
- CHANNELS, 4, number of independent inputs (1..32)
- SYNCSTAGES, 2, synchroniser depth in flops (>= 2)
- WAITTIME, 3, debounce delay in clk cycles (>= 1)
- CNTW (localparam), $clog2(WAITTIME+1), counter width per channel

- clk  input  1  the block's single clock
- reset  input  1  asynchronous, active-high reset
- noisysignal  input  CHANNELS  raw asynchronous inputs
- fault  input  CHANNELS  per-channel force-low (synchronous)
- clearevents  input  CHANNELS  one-cycle clear of sticky flags, per channel
- conditioned  output  CHANNELS  debounced levels
- positiveedge  output  CHANNELS  one-cycle pulse at conditioned rise
- negativeedge  output  CHANNELS  one-cycle pulse at conditioned fall
- posevent  output  CHANNELS  sticky rise-seen flags
- negevent  output  CHANNELS  sticky fall-seen flags
- anyevent  output  1  OR of all posevent and negevent bits

## Operation
- Reset (async assert, sync deassert handled upstream): sync chains, counters, conditioned, positiveedge, negativeedge, posevent, negevent, anyevent all 0.
- Per channel, every edge: noisysignal shifts into sync chain; last stage = s.
- s == conditioned: counter <= 0, no pulse.
- s != conditioned, counter < WAITTIME: counter <= counter+1.
- s != conditioned, counter == WAITTIME: conditioned <= s; positiveedge <= s; negativeedge <= !s; counter <= 0.
- Glitch: s returning to conditioned before count completes clears counter; no output change, no pulse.
- Pulses are 1 for exactly one cycle; otherwise 0.
- fault[i]=1: conditioned[i] <= 0, counter <= 0, both pulses 0; no negativeedge generated by the forcing; sync chain keeps sampling. On release, normal debounce from conditioned=0.
- posevent[i] set on positiveedge[i], negevent[i] on negativeedge[i]; cleared when clearevents[i]=1; simultaneous set and clear: set wins.
- anyevent registered: reflects flag state one cycle after flags change.
- Counter never exceeds WAITTIME; no wrap-around possible.

## Timing
- Stable new value first sampled at edge t0: s changes at edge t0+SYNCSTAGES-1; conditioned and edge pulse at edge t0+SYNCSTAGES+WAITTIME (defaults: t0+5).
- Input pulse shorter than WAITTIME+1 cycles at s is rejected.
- Sticky flag visible at edge after pulse; anyevent one edge later.
- clearevents takes effect at the next edge.
- fault: conditioned low at the edge fault is sampled high.
- Reset mid-debounce: all state zeroed immediately; debounce restarts from scratch after release.
- Channels fully independent; simultaneous events on all channels each produce their own pulse.

## Structure
- Package input_conditioner_pkg: default constants (DEF_CHANNELS, DEF_SYNCSTAGES, DEF_WAITTIME) and counter-width function.
- Sub-module input_conditioner_channel: sync chain, counter, level, pulses, fault, sticky flags for one bit; top generates CHANNELS instances and builds anyevent.

## Test plan
- Reset, then ch0 0->1 step at edge 10 (defaults) -> conditioned[0]=1 and positiveedge[0]=1 for one cycle at edge 15; posevent[0]=1 at 16; anyevent=1 at 17.
- ch1 high pulse of 3 cycles after sync -> no conditioned change, no pulses, counter back to 0.
- ch2 conditioned=1, assert fault[2] -> conditioned[2]=0 next edge, negativeedge[2] stays 0; release with input high -> positiveedge[2] WAITTIME+1 cycles later.
- clearevents[0] on same edge posevent[0] would set -> flag stays 1; clear on later idle cycle -> 0 next edge, anyevent 0 edge after.
- All CHANNELS toggled together -> all positiveedge bits pulse on the same edge.
- Assert reset mid-count (counter=2) -> all outputs 0 immediately; after release, full SYNCSTAGES+WAITTIME latency again.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the multi-channel input conditioner.
package input_conditioner_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_SYNCSTAGES = 2;
  localparam int DEF_WAITTIME   = 3;

  // Width needed to count from 0 up to and including wait_time.
  function automatic int cnt_width(input int wait_time);
    return (wait_time < 1) ? 1 : $clog2(wait_time + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundles the raw inputs, controls and conditioned outputs of the conditioner array.
interface input_conditioner_if
  import input_conditioner_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS
) ();

  logic [CHANNELS-1:0] noisysignal;
  logic [CHANNELS-1:0] fault;
  logic [CHANNELS-1:0] clearevents;
  logic [CHANNELS-1:0] conditioned;
  logic [CHANNELS-1:0] positiveedge;
  logic [CHANNELS-1:0] negativeedge;
  logic [CHANNELS-1:0] posevent;
  logic [CHANNELS-1:0] negevent;
  logic                anyevent;

  modport master (
    output noisysignal, fault, clearevents,
    input  conditioned, positiveedge, negativeedge, posevent, negevent, anyevent
  );

  modport slave (
    input  noisysignal, fault, clearevents,
    output conditioned, positiveedge, negativeedge, posevent, negevent, anyevent
  );

endinterface

// File: rtl/input_conditioner_channel.sv
// One channel: synchroniser chain, debounce counter, conditioned level,
// edge pulses, fault forcing and sticky edge flags.
module input_conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNCSTAGES = DEF_SYNCSTAGES,
  parameter int WAITTIME   = DEF_WAITTIME
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy_in,
  input  logic fault_in,
  input  logic clear_in,
  output logic conditioned,
  output logic positive_edge,
  output logic negative_edge,
  output logic pos_event,
  output logic neg_event
);

  localparam int CNTW = cnt_width(WAITTIME);
  localparam logic [CNTW-1:0] WAIT_LIMIT = CNTW'(WAITTIME);

  logic [SYNCSTAGES-1:0] sync_q, sync_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  cond_q, cond_d;
  logic                  pos_q, pos_d;
  logic                  neg_q, neg_d;
  logic                  posev_q, posev_d;
  logic                  negev_q, negev_d;
  logic                  sync_s;

  assign sync_s = sync_q[SYNCSTAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNCSTAGES-2:0], noisy_in};
    cnt_d  = cnt_q;
    cond_d = cond_q;
    pos_d  = 1'b0;
    neg_d  = 1'b0;
    // Forcing low never produces a falling pulse; the level just drops.
    if (fault_in) begin
      cond_d = 1'b0;
      cnt_d  = '0;
    end else if (sync_s == cond_q) begin
      cnt_d = '0;
    end else if (cnt_q == WAIT_LIMIT) begin
      cond_d = sync_s;
      pos_d  = sync_s;
      neg_d  = ~sync_s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // A new edge outranks a simultaneous software clear.
    posev_d = pos_q | (posev_q & ~clear_in);
    negev_d = neg_q | (negev_q & ~clear_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      cond_q  <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      posev_q <= 1'b0;
      negev_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      cond_q  <= cond_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      posev_q <= posev_d;
      negev_q <= negev_d;
    end
  end

  assign conditioned   = cond_q;
  assign positive_edge = pos_q;
  assign negative_edge = neg_q;
  assign pos_event     = posev_q;
  assign neg_event     = negev_q;

endmodule

// File: rtl/input_conditioner_array.sv
// Array of independent input conditioners plus a registered aggregate event flag.
module input_conditioner_array
  import input_conditioner_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int SYNCSTAGES = DEF_SYNCSTAGES,
  parameter int WAITTIME   = DEF_WAITTIME
) (
  input logic                 clk,
  input logic                 reset,
  input_conditioner_if.slave  bus
);

  logic [CHANNELS-1:0] cond_w;
  logic [CHANNELS-1:0] pos_w;
  logic [CHANNELS-1:0] neg_w;
  logic [CHANNELS-1:0] posev_w;
  logic [CHANNELS-1:0] negev_w;
  logic                anyevent_q, anyevent_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    input_conditioner_channel #(
      .SYNCSTAGES (SYNCSTAGES),
      .WAITTIME   (WAITTIME)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .noisy_in      (bus.noisysignal[i]),
      .fault_in      (bus.fault[i]),
      .clear_in      (bus.clearevents[i]),
      .conditioned   (cond_w[i]),
      .positive_edge (pos_w[i]),
      .negative_edge (neg_w[i]),
      .pos_event     (posev_w[i]),
      .neg_event     (negev_w[i])
    );
  end

  // Registered so the aggregate lags the sticky flags by exactly one cycle.
  always_comb begin
    anyevent_d = |(posev_w | negev_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anyevent_q <= 1'b0;
    end else begin
      anyevent_q <= anyevent_d;
    end
  end

  assign bus.conditioned  = cond_w;
  assign bus.positiveedge = pos_w;
  assign bus.negativeedge = neg_w;
  assign bus.posevent     = posev_w;
  assign bus.negevent     = negev_w;
  assign bus.anyevent     = anyevent_q;

endmodule

// File: tb/tb_input_conditioner_array.sv
// Directed and randomized checks of input_conditioner_array against a timestamp-based reference model.
module tb_input_conditioner_array;
  import input_conditioner_pkg::*;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int W  = 3;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  input_conditioner_if #(.CHANNELS(CH)) bus ();

  input_conditioner_array #(
    .CHANNELS   (CH),
    .SYNCSTAGES (SS),
    .WAITTIME   (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a channel flips once s has disagreed with the level for
  // W+1 consecutive unfaulted edges since the last agreement/fault/flip.
  logic [CH-1:0] m_cond, m_pos, m_neg, m_posev, m_negev;
  logic          m_any;
  int            last_agree [CH];
  int            edge_n;
  logic [CH-1:0] nhist [$];

  task automatic model_reset();
    m_cond  = '0;
    m_pos   = '0;
    m_neg   = '0;
    m_posev = '0;
    m_negev = '0;
    m_any   = 1'b0;
    edge_n  = 0;
    nhist.delete();
    for (int i = 0; i < SS; i++) nhist.push_back('0);
    for (int i = 0; i < CH; i++) last_agree[i] = 0;
  endtask

  task automatic check_output(input string tag);
    logic [5*CH:0] obs, expv;
    obs  = {bus.conditioned, bus.positiveedge, bus.negativeedge,
            bus.posevent, bus.negevent, bus.anyevent};
    expv = {m_cond, m_pos, m_neg, m_posev, m_negev, m_any};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s edge %0d: observed %h expected %h", tag, edge_n, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one clock, update the model from the pre-edge inputs, then compare.
  task automatic tick(input string tag);
    logic [CH-1:0] s_pre;
    logic          any_next;
    @(posedge clk);
    edge_n++;
    s_pre = nhist.pop_front();
    nhist.push_back(bus.noisysignal);
    any_next = |(m_posev | m_negev);
    m_posev  = m_pos | (m_posev & ~bus.clearevents);
    m_negev  = m_neg | (m_negev & ~bus.clearevents);
    m_any    = any_next;
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = 1'b0;
      m_neg[i] = 1'b0;
      if (bus.fault[i]) begin
        m_cond[i]     = 1'b0;
        last_agree[i] = edge_n;
      end else if (s_pre[i] == m_cond[i]) begin
        last_agree[i] = edge_n;
      end else if (edge_n - last_agree[i] >= W + 1) begin
        m_cond[i]     = s_pre[i];
        m_pos[i]      = s_pre[i];
        m_neg[i]      = ~s_pre[i];
        last_agree[i] = edge_n;
      end
    end
    #1;
    check_output(tag);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < CH; i++) begin
      if ($urandom_range(0, 3) == 0) bus.noisysignal[i] = ~bus.noisysignal[i];
      bus.fault[i]       = ($urandom_range(0, 15) == 0);
      bus.clearevents[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.noisysignal = '0;
    bus.fault       = '0;
    bus.clearevents = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_output("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // ch0 step sampled at edge 10
    repeat (9) tick("idle");
    bus.noisysignal[0] = 1'b1;
    repeat (5) tick("ch0_rise");
    check_bit("ch0_cond_e14", bus.conditioned[0], 1'b0);
    tick("ch0_rise");
    check_bit("ch0_cond_e15", bus.conditioned[0], 1'b1);
    check_bit("ch0_pos_e15", bus.positiveedge[0], 1'b1);
    tick("ch0_flag");
    check_bit("ch0_pos_e16", bus.positiveedge[0], 1'b0);
    check_bit("ch0_posev_e16", bus.posevent[0], 1'b1);
    check_bit("any_e16", bus.anyevent, 1'b0);
    tick("ch0_any");
    check_bit("any_e17", bus.anyevent, 1'b1);

    // ch1 glitch of W cycles is rejected, then a full-latency rise
    bus.noisysignal[1] = 1'b1;
    repeat (3) tick("ch1_glitch");
    bus.noisysignal[1] = 1'b0;
    repeat (8) tick("ch1_glitch");
    check_bit("ch1_glitch_cond", bus.conditioned[1], 1'b0);
    check_bit("ch1_glitch_posev", bus.posevent[1], 1'b0);
    bus.noisysignal[1] = 1'b1;
    repeat (5) tick("ch1_rise");
    check_bit("ch1_cond_early", bus.conditioned[1], 1'b0);
    tick("ch1_rise");
    check_bit("ch1_cond_full", bus.conditioned[1], 1'b1);

    // ch2 fault forcing and release
    bus.noisysignal[2] = 1'b1;
    repeat (6) tick("ch2_rise");
    check_bit("ch2_cond_high", bus.conditioned[2], 1'b1);
    bus.fault[2] = 1'b1;
    tick("ch2_fault");
    check_bit("ch2_fault_cond", bus.conditioned[2], 1'b0);
    check_bit("ch2_fault_neg", bus.negativeedge[2], 1'b0);
    repeat (2) tick("ch2_fault");
    check_bit("ch2_fault_negev", bus.negevent[2], 1'b0);
    bus.fault[2] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      tick("ch2_release");
      if (bus.positiveedge[2] === 1'b1) lat = k;
    end
    check_int("ch2_release_latency", lat, W + 1);

    // sticky clear on an idle cycle, then set-wins-over-clear
    bus.noisysignal[0] = 1'b0;
    repeat (8) tick("ch0_fall");
    bus.clearevents = '1;
    tick("clear_all");
    bus.clearevents = '0;
    check_vec("posev_cleared", bus.posevent, '0);
    check_vec("negev_cleared", bus.negevent, '0);
    tick("clear_any");
    check_bit("any_cleared", bus.anyevent, 1'b0);
    bus.noisysignal[0] = 1'b1;
    repeat (6) tick("ch0_rerise");
    check_bit("ch0_pos_rerise", bus.positiveedge[0], 1'b1);
    bus.clearevents[0] = 1'b1;
    tick("set_wins");
    bus.clearevents[0] = 1'b0;
    check_bit("ch0_set_wins", bus.posevent[0], 1'b1);

    // all channels rise together
    bus.noisysignal = '0;
    repeat (8) tick("all_low");
    bus.noisysignal = '1;
    repeat (5) tick("all_rise");
    check_vec("all_pos_early", bus.positiveedge, '0);
    tick("all_rise");
    check_vec("all_pos", bus.positiveedge, '1);

    // reset while ch3 is mid-count
    bus.noisysignal = '0;
    repeat (8) tick("all_fall");
    bus.noisysignal[3] = 1'b1;
    repeat (4) tick("ch3_count");
    reset = 1'b1;
    #1;
    model_reset();
    check_output("reset_async");
    #3 reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick("ch3_after_reset");
      if (bus.conditioned[3] === 1'b1) lat = k;
    end
    check_int("ch3_reset_latency", lat, SS + W + 1);

    // randomized traffic
    repeat (400) begin
      apply_stimulus();
      tick("random");
    end
    bus.fault       = '0;
    bus.clearevents = '0;
    repeat (10) tick("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
